// File: rtl/mmu_port_arbiter.sv
// mmu_port_arbiter: shares the single MMU access port between the
// instruction-fetch path (read-only) and the load/store path (read/write,
// byte-selected). It sequences the MMU retrieve/read_or_write windows,
// captures read data, and returns per-port completion pulses.
//
// Ports:
//   soc_clk, reset        clock, synchronous active-low reset
//   if_req/if_addr        fetch read request (held until if_gnt)
//   if_gnt                fetch accepted this cycle (combinational, IDLE only)
//   if_rvalid/if_rdata    fetch completion pulse / last fetch read data
//   ls_req/ls_we/ls_addr  load/store request (held until ls_gnt)
//   ls_bytesel/ls_wdata   write byte mask / write data
//   ls_gnt                load/store accepted this cycle (combinational)
//   ls_done/ls_rdata      load/store completion pulse / last load read data
//   CU_address, CU_bytesel, CU_dat_in, read_or_write, retrieve  -> MMU
//   MMU_dat_out           <- MMU read data
//   busy                  high whenever the sequencer is not IDLE
module mmu_port_arbiter #(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned OP_CYCLES      = 2,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic              soc_clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [3:0]        ls_bytesel,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,

    output logic [ADDR_W-1:0] CU_address,
    output logic [3:0]        CU_bytesel,
    output logic [DATA_W-1:0] CU_dat_in,
    output logic              read_or_write,
    output logic              retrieve,
    input  logic [DATA_W-1:0] MMU_dat_out,

    output logic              busy
);

    localparam int unsigned MAX_CYC = (OP_CYCLES > RECOVER_CYCLES) ? OP_CYCLES : RECOVER_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESP    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_gnt_if;
    logic               w_gnt_ls;
    logic               w_issue_last;

    // Round-robin memory: 1 = LSU was granted last, 0 = fetch.
    logic               r_last_ls;
    // Owner of the operation in flight: 1 = LSU, 0 = fetch.
    logic               r_owner_ls;

    logic [ADDR_W-1:0]  r_cu_addr;
    logic [3:0]         r_cu_bytesel;
    logic [DATA_W-1:0]  r_cu_dat_in;
    logic               r_rw;
    logic               r_retrieve;
    logic               r_busy;
    logic               r_if_rvalid;
    logic               r_ls_done;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_ls_rdata;

    // Final ISSUE cycle: read data is sampled on the edge that ends it.
    assign w_issue_last = (r_state == ST_ISSUE) && (r_cnt == '0);

    // Next-state, counter and grant decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_if    = 1'b0;
        w_gnt_ls    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // No grant while reset is asserted; the edge would discard it.
                if (reset) begin
                    if (ls_req && (!if_req || !r_last_ls)) begin
                        w_gnt_ls = 1'b1;
                    end else if (if_req) begin
                        w_gnt_if = 1'b1;
                    end
                end
                if (w_gnt_ls || w_gnt_if) begin
                    w_state_nxt = ST_ISSUE;
                    w_cnt_nxt   = CNT_W'(OP_CYCLES - 1);
                end
            end
            ST_ISSUE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_RECOVER;
                w_cnt_nxt   = CNT_W'(RECOVER_CYCLES - 1);
            end
            ST_RECOVER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter register.
    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Winner's fields are frozen on the granting edge and held until the next grant.
    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            r_last_ls    <= 1'b0;
            r_owner_ls   <= 1'b0;
            r_cu_addr    <= '0;
            r_cu_bytesel <= '0;
            r_cu_dat_in  <= '0;
            r_rw         <= 1'b0;
        end else if (w_gnt_ls) begin
            r_last_ls    <= 1'b1;
            r_owner_ls   <= 1'b1;
            r_cu_addr    <= ls_addr;
            r_rw         <= ls_we;
            r_cu_bytesel <= ls_we ? ls_bytesel : 4'b1111;
            r_cu_dat_in  <= ls_we ? ls_wdata : '0;
        end else if (w_gnt_if) begin
            r_last_ls    <= 1'b0;
            r_owner_ls   <= 1'b0;
            r_cu_addr    <= if_addr;
            r_rw         <= 1'b0;
            r_cu_bytesel <= 4'b1111;
            r_cu_dat_in  <= '0;
        end
    end

    // Read-data capture into the owning port's register; writes leave both untouched.
    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else if (w_issue_last && !r_rw) begin
            if (r_owner_ls) begin
                r_ls_rdata <= MMU_dat_out;
            end else begin
                r_if_rdata <= MMU_dat_out;
            end
        end
    end

    // Strobes and pulses are registered from the next state.
    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            r_retrieve  <= 1'b0;
            r_busy      <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_done   <= 1'b0;
        end else begin
            r_retrieve  <= (w_state_nxt == ST_ISSUE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_if_rvalid <= (w_state_nxt == ST_RESP) && !r_owner_ls;
            r_ls_done   <= (w_state_nxt == ST_RESP) && r_owner_ls;
        end
    end

    assign if_gnt        = w_gnt_if;
    assign ls_gnt        = w_gnt_ls;
    assign if_rvalid     = r_if_rvalid;
    assign if_rdata      = r_if_rdata;
    assign ls_done       = r_ls_done;
    assign ls_rdata      = r_ls_rdata;
    assign CU_address    = r_cu_addr;
    assign CU_bytesel    = r_cu_bytesel;
    assign CU_dat_in     = r_cu_dat_in;
    assign read_or_write = r_rw;
    assign retrieve      = r_retrieve;
    assign busy          = r_busy;

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Bench for mmu_port_arbiter: a behavioural MMU memory, a reference memory and a
// cycle model of the grant/issue/response timing; read results are scoreboarded.
module tb_mmu_port_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int OP     = 2;
    localparam int REC    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              soc_clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [3:0]        ls_bytesel;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;
    logic [ADDR_W-1:0] CU_address;
    logic [3:0]        CU_bytesel;
    logic [DATA_W-1:0] CU_dat_in;
    logic              read_or_write;
    logic              retrieve;
    logic [DATA_W-1:0] MMU_dat_out;
    logic              busy;

    always #5 soc_clk = ~soc_clk;

    mmu_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_CYCLES(OP), .RECOVER_CYCLES(REC)
    ) dut (
        .soc_clk(soc_clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_bytesel(ls_bytesel),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .CU_address(CU_address), .CU_bytesel(CU_bytesel), .CU_dat_in(CU_dat_in),
        .read_or_write(read_or_write), .retrieve(retrieve),
        .MMU_dat_out(MMU_dat_out), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural MMU: combinational read, byte-masked write while retrieve is high.
    logic [DATA_W-1:0] mmu_mem [0:DEPTH-1];
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    assign MMU_dat_out = mmu_mem[CU_address];
    always @(posedge soc_clk) begin
        if (retrieve && read_or_write)
            mmu_mem[CU_address] <= merge(mmu_mem[CU_address], CU_dat_in, CU_bytesel);
    end

    logic rst_q;
    always @(posedge soc_clk) rst_q <= ~reset;

    typedef struct {
        logic        ls;
        logic        rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    // Cycle model state
    logic              m_active;
    int                m_since;
    logic              m_last_ls;
    logic              m_owner_ls;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_mask;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_if_rdata;
    logic [DATA_W-1:0] m_ls_rdata;
    int                n_grants;

    initial begin
        logic       exp_ret;
        logic [1:0] exp_pulse;
        logic [1:0] exp_g;
        exp_t       e;
        m_active = 1'b0; m_since = 0; m_last_ls = 1'b0; m_owner_ls = 1'b0;
        m_rw = 1'b0; m_addr = '0; m_mask = '0; m_wdata = '0;
        m_if_rdata = '0; m_ls_rdata = '0; n_grants = 0;
        @(posedge soc_clk);
        forever begin
            @(negedge soc_clk);
            if (rst_q) begin
                m_active = 1'b0; m_last_ls = 1'b0;
                m_if_rdata = '0; m_ls_rdata = '0;
                sb_q.delete();
                chk("rst_cu_addr", 32'(CU_address), 32'd0);
                chk("rst_cu_bytesel", 32'(CU_bytesel), 32'd0);
                chk("rst_cu_dat_in", CU_dat_in, 32'd0);
                chk("rst_rw", 32'(read_or_write), 32'd0);
            end else if (m_active) begin
                m_since++;
                if (m_since >= OP + REC + 2) m_active = 1'b0;
            end

            exp_ret = m_active && (m_since >= 1) && (m_since <= OP);
            chk("retrieve", 32'(retrieve), 32'(exp_ret));
            chk("busy", 32'(busy), 32'(m_active));

            exp_pulse = 2'b00;
            if (m_active && m_since == OP + 1) exp_pulse = m_owner_ls ? 2'b01 : 2'b10;
            chk("pulse{if,ls}", 32'({if_rvalid, ls_done}), 32'(exp_pulse));
            if (exp_pulse != 2'b00) begin
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("sb_port", 32'(e.ls), 32'(m_owner_ls));
                    if (e.rd) begin
                        if (e.ls) m_ls_rdata = e.data;
                        else      m_if_rdata = e.data;
                    end
                end
            end
            if (!rst_q) begin
                chk("if_rdata", if_rdata, m_if_rdata);
                chk("ls_rdata", ls_rdata, m_ls_rdata);
            end else begin
                chk("rst_if_rdata", if_rdata, 32'd0);
                chk("rst_ls_rdata", ls_rdata, 32'd0);
            end

            if (m_active) begin
                chk("cu_addr", 32'(CU_address), 32'(m_addr));
                chk("cu_rw", 32'(read_or_write), 32'(m_rw));
                chk("cu_bytesel", 32'(CU_bytesel), 32'(m_mask));
                if (m_rw || !m_owner_ls) chk("cu_dat_in", CU_dat_in, m_wdata);
            end

            exp_g = 2'b00;
            if (!m_active && reset) begin
                if (ls_req && (!if_req || !m_last_ls)) exp_g = 2'b01;
                else if (if_req)                       exp_g = 2'b10;
            end
            chk("grant{if,ls}", 32'({if_gnt, ls_gnt}), 32'(exp_g));

            if (exp_g != 2'b00) begin
                m_active   = 1'b1;
                m_since    = 0;
                m_owner_ls = exp_g[0];
                m_last_ls  = exp_g[0];
                n_grants++;
                if (exp_g[0]) begin
                    m_rw    = ls_we;
                    m_addr  = ls_addr;
                    m_mask  = ls_we ? ls_bytesel : 4'hF;
                    m_wdata = ls_we ? ls_wdata : '0;
                end else begin
                    m_rw    = 1'b0;
                    m_addr  = if_addr;
                    m_mask  = 4'hF;
                    m_wdata = '0;
                end
                e.ls = m_owner_ls;
                e.rd = !m_rw;
                if (m_rw) begin
                    ref_mem[m_addr] = merge(ref_mem[m_addr], m_wdata, m_mask);
                    e.data = '0;
                end else begin
                    e.data = ref_mem[m_addr];
                end
                sb_q.push_back(e);
            end
        end
    end

    task automatic wait_gnt(input logic is_ls);
        int n;
        logic g;
        n = 0;
        g = 1'b0;
        while (!g && n < 40) begin
            @(negedge soc_clk);
            g = is_ls ? ls_gnt : if_gnt;
            n++;
        end
        chk(is_ls ? "ls_gnt_wait" : "if_gnt_wait", 32'(g), 32'd1);
        @(posedge soc_clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge soc_clk);
            n++;
        end while (busy && n < 20);
        chk("idle_wait", 32'(busy), 32'd0);
        @(posedge soc_clk); #1;
    endtask

    task automatic scramble_ls();
        ls_we      = 1'($urandom);
        ls_addr    = 7'($urandom);
        ls_bytesel = 4'($urandom);
        ls_wdata   = $urandom;
    endtask

    task automatic ls_op(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [3:0] m, input logic [31:0] d);
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_bytesel = m; ls_wdata = d;
        wait_gnt(1'b1);
        ls_req = 1'b0;
        scramble_ls();
        wait_idle();
    endtask

    task automatic if_op(input logic [ADDR_W-1:0] a);
        if_req = 1'b1; if_addr = a;
        wait_gnt(1'b0);
        if_req = 1'b0;
        if_addr = 7'($urandom);
        wait_idle();
    endtask

    initial begin
        int g0;
        for (int i = 0; i < DEPTH; i++) begin
            mmu_mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b0;
        if_req = 1'b1; if_addr = 7'd3;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 7'd0; ls_bytesel = 4'hF; ls_wdata = '0;

        // Reset held with both requests high, then LSU wins the first tie
        repeat (3) @(posedge soc_clk);
        #1 reset = 1'b1;
        wait_gnt(1'b1);
        ls_req = 1'b0; if_req = 1'b0;
        wait_idle();

        // LSU write then read
        ls_op(1'b1, 7'd0, 4'hF, 32'hDEADBEEF);
        ls_op(1'b0, 7'd0, 4'hF, 32'h0);

        // Byte mask, including an empty mask
        ls_op(1'b1, 7'd2, 4'hF, 32'hFFFFFFFF);
        ls_op(1'b1, 7'd2, 4'b0001, 32'h0);
        ls_op(1'b0, 7'd2, 4'hF, 32'h0);
        ls_op(1'b1, 7'd2, 4'b0000, 32'h0);
        ls_op(1'b0, 7'd2, 4'hF, 32'h0);

        // Fetch only
        ls_op(1'b1, 7'd10, 4'hF, 32'hA5A5A5A5);
        if_op(7'd10);

        // Round-robin with both requests held
        g0 = n_grants;
        if_req = 1'b1; if_addr = 7'd10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 7'd0;
        repeat (26) begin
            @(posedge soc_clk); #1;
            if_addr    = 7'($urandom_range(0, 15));
            ls_we      = 1'($urandom);
            ls_addr    = 7'($urandom_range(0, 15));
            ls_bytesel = 4'($urandom);
            ls_wdata   = $urandom;
        end
        if_req = 1'b0; ls_req = 1'b0;
        wait_idle();
        chk("rr_grant_count", 32'(n_grants - g0 >= 4), 32'd1);

        // Random traffic, including requests withdrawn before grant
        repeat (300) begin
            @(posedge soc_clk); #1;
            if_req     = 1'($urandom);
            if_addr    = 7'($urandom_range(0, 15));
            ls_req     = 1'($urandom);
            ls_we      = 1'($urandom);
            ls_addr    = 7'($urandom_range(0, 15));
            ls_bytesel = 4'($urandom);
            ls_wdata   = $urandom;
        end
        if_req = 1'b0; ls_req = 1'b0;
        wait_idle();

        // Reset during the second ISSUE cycle of a write aborts it
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 7'd20; ls_bytesel = 4'hF; ls_wdata = 32'h12345678;
        wait_gnt(1'b1);
        ls_req = 1'b0;
        @(posedge soc_clk); #1;
        reset = 1'b0;
        @(posedge soc_clk); #1;
        reset = 1'b1;
        repeat (8) @(posedge soc_clk);
        #1;
        chk("abort_idle", 32'(busy), 32'd0);

        // Normal operation resumes after the abort
        ls_op(1'b0, 7'd10, 4'hF, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
